// File: rtl/qea_run_sequencer_if.sv
// Host-side streams of the run sequencer: context words in, final state rows out.
interface qea_run_sequencer_if #(
  parameter int GATE_CONTEXT_DATA_WIDTH = 64,
  parameter int STATE_ADDR_WIDTH        = 16,
  parameter int ROW_WIDTH               = 256
);
  logic                               i_ctx_valid;
  logic [GATE_CONTEXT_DATA_WIDTH-1:0] i_ctx_data;
  logic                               o_ctx_ready;
  logic                               o_rd_valid;
  logic [ROW_WIDTH-1:0]               o_rd_data;
  logic [STATE_ADDR_WIDTH-1:0]        o_rd_addr;
  logic                               o_rd_last;
  logic                               i_rd_ready;

  modport master (
    output i_ctx_valid, i_ctx_data, i_rd_ready,
    input  o_ctx_ready, o_rd_valid, o_rd_data, o_rd_addr, o_rd_last
  );
  modport slave (
    input  i_ctx_valid, i_ctx_data, i_rd_ready,
    output o_ctx_ready, o_rd_valid, o_rd_data, o_rd_addr, o_rd_last
  );
endinterface

// File: rtl/qea_run_sequencer.sv
// QEA host sequencer: loads context and initial basis state, starts the core,
// times the run with a timeout guard, then streams the final state vector out.
module qea_run_sequencer #(
  parameter int PE_NUM_WIDTH            = 2,
  parameter int PE_NUM                  = 2**PE_NUM_WIDTH,
  parameter int STATE_DATA_WIDTH        = 64,
  parameter int STATE_ADDR_WIDTH        = 16,
  parameter int GATE_CONTEXT_DATA_WIDTH = 64,
  parameter int GATE_CONTEXT_ADDR_WIDTH = 16,
  parameter int MAX_QBIT_WIDTH          = 6,
  parameter logic [STATE_DATA_WIDTH-1:0] INIT_AMP = 64'h40000000_00000000,
  parameter int RD_LAT                  = 1,
  parameter int CYC_WIDTH               = 32
) (
  input  logic                                     clk,
  input  logic                                     rst,
  input  logic                                     i_start,
  input  logic [MAX_QBIT_WIDTH-1:0]                i_qbit_num,
  input  logic [GATE_CONTEXT_ADDR_WIDTH:0]         i_ins_num,
  input  logic [STATE_ADDR_WIDTH+PE_NUM_WIDTH-1:0] i_basis_idx,
  qea_run_sequencer_if.slave                       host,
  output logic                                     o_qea_ctx_en,
  output logic                                     o_qea_ctx_wea,
  output logic [GATE_CONTEXT_ADDR_WIDTH-1:0]       o_qea_ctx_addr,
  output logic [GATE_CONTEXT_DATA_WIDTH-1:0]       o_qea_ctx_data,
  output logic                                     o_qea_state_ena,
  output logic                                     o_qea_state_wea,
  output logic [STATE_ADDR_WIDTH-1:0]              o_qea_state_addra,
  output logic [PE_NUM*STATE_DATA_WIDTH-1:0]       o_qea_state_dina,
  output logic                                     o_qea_start,
  input  logic                                     i_qea_complete,
  input  logic [PE_NUM*STATE_DATA_WIDTH-1:0]       i_qea_state_dout,
  output logic                                     o_busy,
  output logic                                     o_done,
  output logic                                     o_timeout,
  output logic [CYC_WIDTH-1:0]                     o_cycles
);
  localparam int BW  = STATE_ADDR_WIDTH + PE_NUM_WIDTH;
  localparam int RW  = PE_NUM * STATE_DATA_WIDTH;
  localparam int CAW = GATE_CONTEXT_ADDR_WIDTH;
  localparam int SAW = STATE_ADDR_WIDTH;
  localparam logic [CAW:0] CTX_DEPTH = {1'b1, {CAW{1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD_CTX, S_LOAD_STATE, S_START, S_RUN, S_READ, S_DONE
  } state_t;

  state_t                       state_q, state_d;
  logic [CAW:0]                 ins_q, ins_d, ctx_cnt_q, ctx_cnt_d;
  logic [BW-1:0]                basis_q, basis_d;
  logic [SAW-1:0]               last_row_q, last_row_d, row_q, row_d;
  logic                         ctx_en_q, ctx_en_d;
  logic [CAW-1:0]               ctx_addr_q, ctx_addr_d;
  logic [GATE_CONTEXT_DATA_WIDTH-1:0] ctx_data_q, ctx_data_d;
  logic [RD_LAT-1:0]            rd_vld_q;
  logic                         rd_issue, drain;
  logic [SAW-1:0]               rd_tag_q, rd_tag_d, out_addr_q, out_addr_d;
  logic                         iss_done_q, iss_done_d, out_vld_q, out_vld_d;
  logic [RW-1:0]                out_data_q, out_data_d;
  logic [CYC_WIDTH-1:0]         cyc_q, cyc_d;
  logic                         tmo_q, tmo_d;
  logic [SAW:0]                 span;

  always_comb begin
    state_d    = state_q;
    ins_d      = ins_q;
    basis_d    = basis_q;
    last_row_d = last_row_q;
    ctx_cnt_d  = ctx_cnt_q;
    ctx_en_d   = 1'b0;
    ctx_addr_d = ctx_addr_q;
    ctx_data_d = ctx_data_q;
    row_d      = row_q;
    rd_tag_d   = rd_tag_q;
    iss_done_d = iss_done_q;
    out_vld_d  = out_vld_q;
    out_data_d = out_data_q;
    out_addr_d = out_addr_q;
    cyc_d      = cyc_q;
    tmo_d      = tmo_q;
    rd_issue   = 1'b0;
    drain      = 1'b0;
    span       = {{SAW{1'b0}}, 1'b1} << (i_qbit_num - MAX_QBIT_WIDTH'(PE_NUM_WIDTH));
    case (state_q)
      S_IDLE: begin
        if (i_start) begin
          tmo_d     = 1'b0;
          ctx_cnt_d = '0;
          row_d     = '0;
          ins_d     = (i_ins_num > CTX_DEPTH) ? CTX_DEPTH : i_ins_num;
          // Shifts past BW leave the whole index in range.
          basis_d   = i_basis_idx & ~({BW{1'b1}} << i_qbit_num);
          last_row_d = (i_qbit_num <= MAX_QBIT_WIDTH'(PE_NUM_WIDTH)) ? '0
                                                                      : span[SAW-1:0] - 1'b1;
          state_d   = (i_ins_num == '0) ? S_LOAD_STATE : S_LOAD_CTX;
        end
      end
      S_LOAD_CTX: begin
        if (host.i_ctx_valid) begin
          ctx_en_d   = 1'b1;
          ctx_addr_d = ctx_cnt_q[CAW-1:0];
          ctx_data_d = host.i_ctx_data;
          ctx_cnt_d  = ctx_cnt_q + 1'b1;
          if (ctx_cnt_d == ins_q) state_d = S_LOAD_STATE;
        end
      end
      S_LOAD_STATE: begin
        row_d = row_q + 1'b1;
        if (row_q == last_row_q) begin
          row_d   = '0;
          state_d = S_START;
        end
      end
      S_START: begin
        cyc_d      = '0;
        iss_done_d = 1'b0;
        state_d    = S_RUN;
      end
      S_RUN: begin
        cyc_d = cyc_q + 1'b1;
        // The first two RUN cycles may still see a stale complete level.
        if (i_qea_complete && cyc_q >= CYC_WIDTH'(2)) begin
          state_d = S_READ;
        end else if (&cyc_d) begin
          tmo_d   = 1'b1;
          state_d = S_DONE;
        end
      end
      S_READ: begin
        drain = out_vld_q && host.i_rd_ready;
        if (drain) begin
          out_vld_d = 1'b0;
          if (out_addr_q == last_row_q) state_d = S_DONE;
        end
        if (!iss_done_q && !(|rd_vld_q) && (!out_vld_q || drain)) begin
          rd_issue = 1'b1;
          rd_tag_d = row_q;
          row_d    = row_q + 1'b1;
          if (row_q == last_row_q) iss_done_d = 1'b1;
        end
        if (rd_vld_q[RD_LAT-1]) begin
          out_vld_d  = 1'b1;
          out_data_d = i_qea_state_dout;
          out_addr_d = rd_tag_q;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      ins_q      <= '0;
      basis_q    <= '0;
      last_row_q <= '0;
      ctx_cnt_q  <= '0;
      ctx_en_q   <= 1'b0;
      ctx_addr_q <= '0;
      ctx_data_q <= '0;
      row_q      <= '0;
      rd_vld_q   <= '0;
      rd_tag_q   <= '0;
      iss_done_q <= 1'b0;
      out_vld_q  <= 1'b0;
      out_data_q <= '0;
      out_addr_q <= '0;
      cyc_q      <= '0;
      tmo_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      ins_q      <= ins_d;
      basis_q    <= basis_d;
      last_row_q <= last_row_d;
      ctx_cnt_q  <= ctx_cnt_d;
      ctx_en_q   <= ctx_en_d;
      ctx_addr_q <= ctx_addr_d;
      ctx_data_q <= ctx_data_d;
      row_q      <= row_d;
      rd_vld_q[0] <= rd_issue;
      for (int i = 1; i < RD_LAT; i++) rd_vld_q[i] <= rd_vld_q[i-1];
      rd_tag_q   <= rd_tag_d;
      iss_done_q <= iss_done_d;
      out_vld_q  <= out_vld_d;
      out_data_q <= out_data_d;
      out_addr_q <= out_addr_d;
      cyc_q      <= cyc_d;
      tmo_q      <= tmo_d;
    end
  end

  logic wr_state;
  assign wr_state = (state_q == S_LOAD_STATE);

  // Lane 0 sits in the most significant slot of a row.
  for (genvar l = 0; l < PE_NUM; l++) begin : g_lane
    assign o_qea_state_dina[(PE_NUM-l)*STATE_DATA_WIDTH-1 -: STATE_DATA_WIDTH] =
      (wr_state && row_q == basis_q[BW-1:PE_NUM_WIDTH] &&
       basis_q[PE_NUM_WIDTH-1:0] == PE_NUM_WIDTH'(l)) ? INIT_AMP : '0;
  end

  assign o_qea_state_ena   = wr_state || rd_issue;
  assign o_qea_state_wea   = wr_state;
  assign o_qea_state_addra = row_q;
  assign o_qea_ctx_en      = ctx_en_q;
  assign o_qea_ctx_wea     = ctx_en_q;
  assign o_qea_ctx_addr    = ctx_addr_q;
  assign o_qea_ctx_data    = ctx_data_q;
  assign o_qea_start       = (state_q == S_START);
  assign o_busy            = (state_q != S_IDLE);
  assign o_done            = (state_q == S_DONE);
  assign o_timeout         = tmo_q;
  assign o_cycles          = cyc_q;

  assign host.o_ctx_ready = (state_q == S_LOAD_CTX);
  assign host.o_rd_valid  = out_vld_q;
  assign host.o_rd_data   = out_data_q;
  assign host.o_rd_addr   = out_addr_q;
  assign host.o_rd_last   = out_vld_q && (out_addr_q == last_row_q);
endmodule

// File: tb/tb_qea_run_sequencer.sv
// Scoreboard bench: stimulus pushes expected writes/rows, monitors pop and compare.
module tb_qea_run_sequencer;
  localparam int RW = 256;
  localparam logic [63:0] AMP = 64'h40000000_00000000;

  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;

  logic        start, start2;
  logic [5:0]  qbit;
  logic [16:0] ins;
  logic [17:0] basis;
  logic        ctx_en, ctx_wea, st_ena, st_wea, qstart, cpl, busy, done, tmo;
  logic [15:0] ctx_addr, st_addr;
  logic [63:0] ctx_data;
  logic [RW-1:0] st_dina;
  logic [RW-1:0] st_dout = '0;
  logic [31:0] cycles;
  logic        c2_en, c2_wea, s2_ena, s2_wea, qstart2, busy2, done2, tmo2;
  logic [15:0] c2_addr, s2_addr;
  logic [63:0] c2_data;
  logic [RW-1:0] s2_dina;
  logic [RW-1:0] dout2 = '0;
  logic        cpl2 = 1'b0;
  logic [7:0]  cyc2;

  qea_run_sequencer_if hif ();
  qea_run_sequencer_if hif2 ();

  qea_run_sequencer dut (
    .clk(clk), .rst(rst), .i_start(start), .i_qbit_num(qbit), .i_ins_num(ins),
    .i_basis_idx(basis), .host(hif),
    .o_qea_ctx_en(ctx_en), .o_qea_ctx_wea(ctx_wea), .o_qea_ctx_addr(ctx_addr),
    .o_qea_ctx_data(ctx_data), .o_qea_state_ena(st_ena), .o_qea_state_wea(st_wea),
    .o_qea_state_addra(st_addr), .o_qea_state_dina(st_dina), .o_qea_start(qstart),
    .i_qea_complete(cpl), .i_qea_state_dout(st_dout), .o_busy(busy), .o_done(done),
    .o_timeout(tmo), .o_cycles(cycles)
  );

  qea_run_sequencer #(.CYC_WIDTH(8)) dut2 (
    .clk(clk), .rst(rst), .i_start(start2), .i_qbit_num(qbit), .i_ins_num(ins),
    .i_basis_idx(basis), .host(hif2),
    .o_qea_ctx_en(c2_en), .o_qea_ctx_wea(c2_wea), .o_qea_ctx_addr(c2_addr),
    .o_qea_ctx_data(c2_data), .o_qea_state_ena(s2_ena), .o_qea_state_wea(s2_wea),
    .o_qea_state_addra(s2_addr), .o_qea_state_dina(s2_dina), .o_qea_start(qstart2),
    .i_qea_complete(cpl2), .i_qea_state_dout(dout2), .o_busy(busy2), .o_done(done2),
    .o_timeout(tmo2), .o_cycles(cyc2)
  );

  int n_chk = 0, n_fail = 0, n_starts = 0;
  logic sb_en = 1'b0;
  logic [79:0]  ctx_q[$];
  logic [271:0] st_q[$];
  logic [272:0] rd_q[$];

  task automatic chk(input string nm, input logic [287:0] act, input logic [287:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic fail(input string nm);
    n_chk++;
    n_fail++;
    $display("FAIL %s: bound expired or unexpected event", nm);
  endtask

  function automatic logic [RW-1:0] pat(input logic [15:0] a);
    logic [63:0] w;
    w = {16'hFACE, a, ~a, 16'h0BEE};
    return {w, w, w, w};
  endfunction

  // State RAM read port with one cycle latency and an address-derived image.
  always @(posedge clk) if (st_ena && !st_wea) st_dout <= pat(st_addr);

  logic          stall_q = 1'b0;
  logic [15:0]   hold_addr;
  logic [RW-1:0] hold_data;

  always @(negedge clk) begin
    if (sb_en && !rst) begin
      if (qstart) n_starts++;
      if (ctx_en) begin
        if (ctx_q.size() == 0) fail("ctx_extra_write");
        else chk("ctx_write", {ctx_wea, ctx_addr, ctx_data}, {1'b1, ctx_q.pop_front()});
      end
      if (st_ena && st_wea) begin
        if (st_q.size() == 0) fail("state_extra_write");
        else chk("state_write", {st_addr, st_dina}, st_q.pop_front());
      end
      if (stall_q)
        chk("rd_hold", {hif.o_rd_valid, hif.o_rd_addr, hif.o_rd_data}, {1'b1, hold_addr, hold_data});
      if (hif.o_rd_valid && hif.i_rd_ready) begin
        if (rd_q.size() == 0) fail("rd_extra_row");
        else chk("rd_row", {hif.o_rd_addr, hif.o_rd_data, hif.o_rd_last}, rd_q.pop_front());
      end
      stall_q   = hif.o_rd_valid && !hif.i_rd_ready;
      hold_addr = hif.o_rd_addr;
      hold_data = hif.o_rd_data;
    end else begin
      stall_q = 1'b0;
    end
  end

  // QEA completion model: a stray pulse in RUN cycle 1, real completion 37 cycles after start.
  int cpl_dly = 37;
  initial begin
    cpl = 1'b0;
    forever begin
      @(negedge clk);
      if (qstart && !rst) begin
        for (int n = 1; n <= cpl_dly; n++) begin
          @(posedge clk); #1;
          if (n == 2) cpl = 1'b1;
          else if (n == 3) cpl = 1'b0;
          if (n == cpl_dly) cpl = 1'b1;
        end
        while (busy) @(negedge clk);
        cpl = 1'b0;
      end
    end
  end

  task automatic run(input int nq, input int ni, input int bidx, input bit gaps, input bit stall,
                     input logic [63:0] dbase, input int nrows, input int hot,
                     input logic [RW-1:0] hot_val);
    int s0;
    for (int i = 0; i < ni; i++) ctx_q.push_back({16'(i), dbase + 64'(i)});
    for (int r = 0; r < nrows; r++) st_q.push_back({16'(r), (r == hot) ? hot_val : {RW{1'b0}}});
    for (int r = 0; r < nrows; r++) rd_q.push_back({16'(r), pat(16'(r)), r == nrows - 1});
    s0 = n_starts;
    @(posedge clk); #1;
    qbit = 6'(nq); ins = 17'(ni); basis = 18'(bidx); start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    fork
      begin : ctx_drv
        int i = 0, g = 0;
        while (i < ni && g < 20000) begin
          g++;
          hif.i_ctx_valid = !(gaps && g[0]);
          hif.i_ctx_data  = dbase + 64'(i);
          // A start request while busy must be ignored, including its parameters.
          start = (i == 2);
          qbit  = (i == 2) ? 6'd3 : 6'(nq);
          @(negedge clk);
          if (hif.i_ctx_valid && hif.o_ctx_ready) i++;
          @(posedge clk); #1;
        end
        hif.i_ctx_valid = 1'b0;
        start = 1'b0;
        qbit  = 6'(nq);
        if (i < ni) fail("ctx_stream_wait");
      end
      begin : rdy_drv
        if (stall) begin
          hif.i_rd_ready = 1'b0;
          for (int r = 0; r < nrows; r++) begin
            int g = 0;
            do begin @(negedge clk); g++; end while (!hif.o_rd_valid && g < 5000);
            if (!hif.o_rd_valid) fail("rd_valid_wait");
            if (hif.o_rd_addr == 16'd3) repeat (9) @(posedge clk);
            @(posedge clk); #1 hif.i_rd_ready = 1'b1;
            @(posedge clk); #1 hif.i_rd_ready = 1'b0;
          end
          hif.i_rd_ready = 1'b1;
        end
      end
      begin : done_wait
        int g = 0;
        do begin @(negedge clk); g++; end while (!done && g < 20000);
        if (!done) fail("done_wait");
        else begin
          chk("cycles", cycles, 37);
          chk("timeout", tmo, 0);
        end
      end
    join
    @(negedge clk);
    chk("busy_after_done", {busy, done}, 0);
    chk("start_pulses", n_starts - s0, 1);
    chk("ctx_left", ctx_q.size(), 0);
    chk("state_left", st_q.size(), 0);
    chk("rd_left", rd_q.size(), 0);
  endtask

  initial begin
    start = 1'b0; start2 = 1'b0; qbit = '0; ins = '0; basis = '0;
    hif.i_ctx_valid = 1'b0; hif.i_ctx_data = '0; hif.i_rd_ready = 1'b1;
    hif2.i_ctx_valid = 1'b0; hif2.i_ctx_data = '0; hif2.i_rd_ready = 1'b1;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_strobes", {ctx_en, ctx_wea, st_ena, st_wea, qstart, hif.o_ctx_ready,
                          hif.o_rd_valid, hif.o_rd_last, busy, done, tmo}, 0);
    chk("reset_buses", {ctx_addr, ctx_data, st_addr, cycles}, 0);
    chk("reset_dina", st_dina, 0);
    chk("reset_dut2", {busy2, done2, tmo2, cyc2, qstart2}, 0);
    @(posedge clk); #1 rst = 1'b0;
    sb_en = 1'b1;

    // 9 qubits, 1327 words back to back, basis 0 -> row 0 lane 0 hot.
    run(9, 1327, 0, 1'b0, 1'b0, 64'hC0DE_0000_0000_0000, 128, 0, {AMP, 192'h0});

    // Reset in the middle of LOAD_STATE.
    sb_en = 1'b0;
    @(posedge clk); #1;
    qbit = 6'd9; ins = '0; basis = '0; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    begin
      int g = 0;
      do begin @(negedge clk); g++; end while (!st_wea && g < 100);
      if (!st_wea) fail("load_state_wait");
    end
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("rst_mid_strobes", {st_ena, st_wea, ctx_en, ctx_wea, qstart, hif.o_rd_valid}, 0);
    chk("rst_mid_idle", {busy, done}, 0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_mid_stays_idle", {busy, st_ena}, 0);
    sb_en = 1'b1;

    // 4 qubits, basis 6 -> row 1 lane 2 (bits 127:64); gapped stream; readout stall on row 3.
    run(4, 5, 6, 1'b1, 1'b1, 64'hB000_0000_0000_0000, 4, 1, {128'h0, AMP, 64'h0});

    // 8-bit cycle counter with completion never arriving.
    sb_en = 1'b0;
    @(posedge clk); #1;
    qbit = 6'd2; ins = '0; basis = '0; start2 = 1'b1;
    @(posedge clk); #1 start2 = 1'b0;
    begin
      int g = 0, n = 0, seen_rd = 0, seen_wr = 0;
      do begin @(negedge clk); g++; end while (!qstart2 && g < 100);
      if (!qstart2) fail("tmo_start_wait");
      do begin
        @(negedge clk); n++;
        if (hif2.o_rd_valid) seen_rd++;
        if (s2_wea || c2_wea || s2_ena) seen_wr++;
      end while (!done2 && n < 1000);
      chk("tmo_run_len", n, 256);
      chk("tmo_flag", tmo2, 1);
      chk("tmo_cycles", cyc2, 8'hFF);
      chk("tmo_no_readout", seen_rd, 0);
      chk("tmo_no_strobes", seen_wr, 0);
      @(negedge clk);
      chk("tmo_sticky", {busy2, tmo2}, 2'b01);
      @(posedge clk); #1 start2 = 1'b1;
      @(posedge clk); #1 start2 = 1'b0;
      @(negedge clk);
      chk("tmo_cleared_on_start", {busy2, tmo2}, 2'b10);
      g = 0;
      do begin @(negedge clk); g++; end while (!done2 && g < 1000);
      if (!done2) fail("tmo_done2_wait");
      else chk("tmo_again", {tmo2, cyc2}, 9'h1FF);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
